// File: rtl/data_mem_responder_if.sv
// Initiator <-> data memory responder bus: level request in, one-cycle ready strobe out.
interface data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed number of wait states per access,
// alignment/range error reporting and a one-cycle response strobe.
module data_mem_responder #(
  parameter int ADDR_W = 6,
  parameter int WAIT   = 2
) (
  input  logic                 clock_i,
  input  logic                 resetn_i,
  data_mem_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT > 0) ? WAIT - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        rd_en_q, rd_en_d;
  logic        enter_resp;

  logic [31:0] mem [DEPTH];
  logic [31:0] mem_rd_q;

  // With WAIT=0 the response is built on the accepting edge, before addr_q
  // holds the request, so the access address bypasses the latch in IDLE.
  logic [31:0]       acc_addr;
  logic              acc_we;
  logic              acc_valid;
  logic [ADDR_W-1:0] acc_idx;
  logic              mem_we;

  assign acc_addr  = (state_q == ST_IDLE) ? bus.addr : addr_q;
  assign acc_we    = (state_q == ST_IDLE) ? bus.we   : we_q;
  assign acc_valid = (acc_addr[1:0] == 2'b00) && (acc_addr[31:ADDR_W+2] == '0);
  assign acc_idx   = acc_addr[ADDR_W+1:2];
  assign mem_we    = (state_q == ST_RESP) && we_q && !err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rd_en_d    = 1'b0;
    enter_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addr;
          we_d    = bus.we;
          wdata_d = bus.wdata;
          if (WAIT > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      ready_d = 1'b1;
      err_d   = !acc_valid;
      rd_en_d = acc_valid && !acc_we;
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rd_en_q <= rd_en_d;
    end
  end

  // Memory is deliberately outside the reset domain; an aborted store never
  // reaches RESP, so it never writes.
  always_ff @(posedge clock_i) begin
    if (mem_we) begin
      mem[addr_q[ADDR_W+1:2]] <= wdata_q;
    end
    mem_rd_q <= mem[acc_idx];
  end

  assign bus.rdata = rd_en_q ? mem_rd_q : 32'h0;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != ST_IDLE);

endmodule
